// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter -- snoop-bus arbiter for NUM_CACHE private caches.
//
// Picks one requesting cache per bus slot, round-robin starting at r_ptr, and
// broadcasts its transaction on the snoop bus for exactly one cycle together
// with a one-hot grant pulse. When the memory controller reports busy during
// the issue cycle, the arbiter parks in BLOCK until memory is free again.
//
// Optional feature: define BUS_ARBITER_STATS_EN to add per-cache grant
// counters and a stall counter (16-bit, saturating, cleared by reset).
//
// Ports
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req          in   [NUM_CACHE]          level request per cache
//   req_tx       in   [NUM_CACHE] bus_tx_t requested transaction
//   req_addr     in   [NUM_CACHE][XLEN]    requested line address
//   arbiter_busy in   memory controller busy
//   xbar_active  in   any cache-to-memory xbar transfer in flight
//   bus_msg      out  registered snoop message (valid/source/addr/bus_tx)
//   gnt          out  [NUM_CACHE] one-hot grant, same cycle as bus_msg.valid
//   busy         out  FSM not in IDLE
//   grant_cnt    out  [NUM_CACHE][16] grants per cache   (stats build only)
//   stall_cnt    out  [16] cycles with a request and no grant (stats build only)
// -----------------------------------------------------------------------------

package types;
  localparam int NUM_CACHE = 4;
  localparam int XLEN      = 32;
  localparam int SRC_W     = $clog2(NUM_CACHE);

  typedef enum logic [1:0] {
    BUS_NONE = 2'd0,
    GETS     = 2'd1,
    GETM     = 2'd2,
    PUTM     = 2'd3
  } bus_tx_t;

  typedef struct packed {
    logic             valid;
    logic [SRC_W-1:0] source;
    logic [XLEN-1:0]  addr;
    bus_tx_t          bus_tx;
  } bus_msg_t;
endpackage

module bus_arbiter #(
  parameter int NUM_CACHE = types::NUM_CACHE,
  parameter int XLEN      = types::XLEN
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CACHE-1:0]            req,
  input  types::bus_tx_t [NUM_CACHE-1:0]  req_tx,
  input  logic [NUM_CACHE-1:0][XLEN-1:0]  req_addr,
  input  logic                            arbiter_busy,
  input  logic                            xbar_active,
  output types::bus_msg_t                 bus_msg,
  output logic [NUM_CACHE-1:0]            gnt,
  output logic                            busy
`ifdef BUS_ARBITER_STATS_EN
  ,
  output logic [NUM_CACHE-1:0][15:0]      grant_cnt,
  output logic [15:0]                     stall_cnt
`endif
);

  localparam int PW = $clog2(NUM_CACHE);
  localparam int SW = types::SRC_W;
  localparam int AW = types::XLEN;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BLOCK = 2'd2;

  logic [1:0]           r_state;
  logic [PW-1:0]        r_ptr;
  types::bus_msg_t      r_msg;
  logic [NUM_CACHE-1:0] r_gnt;

  logic                 w_found;
  logic [PW-1:0]        w_winner;
  logic [PW-1:0]        w_ptr_nxt;
  logic [NUM_CACHE-1:0] w_gnt_oh;
  logic                 w_sel;
  types::bus_msg_t      w_msg;

  // Round-robin search: first requester at r_ptr, r_ptr+1, ... mod NUM_CACHE.
  always_comb begin
    int idx;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_CACHE; k++) begin
      idx = (int'(r_ptr) + k) % NUM_CACHE;
      if (!w_found && req[idx]) begin
        w_found  = 1'b1;
        w_winner = PW'(idx);
      end
    end
  end

  // Pointer moves just past the winner so it has lowest priority next round.
  assign w_ptr_nxt = (w_winner == PW'(NUM_CACHE-1)) ? '0 : w_winner + PW'(1);

  always_comb begin
    w_gnt_oh           = '0;
    w_gnt_oh[w_winner] = 1'b1;
  end

  // A new slot only opens when memory is idle and no xbar data is moving;
  // otherwise a snooped response could race an in-flight writeback.
  assign w_sel = (r_state == S_IDLE) && w_found && !arbiter_busy && !xbar_active;

  always_comb begin
    w_msg        = '0;
    w_msg.valid  = 1'b1;
    w_msg.source = SW'(w_winner);
    w_msg.addr   = AW'(req_addr[w_winner]);
    w_msg.bus_tx = req_tx[w_winner];
  end

  // bus_msg/gnt are cleared every cycle by default, so they can only be
  // non-zero in the single ISSUE cycle following a selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_msg   <= '0;
      r_gnt   <= '0;
    end else begin
      r_msg <= '0;
      r_gnt <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_sel) begin
            r_state <= S_ISSUE;
            r_ptr   <= w_ptr_nxt;
            r_msg   <= w_msg;
            r_gnt   <= w_gnt_oh;
          end
        end
        // arbiter_busy here is memory reacting combinationally to the message
        // currently on the bus (e.g. PUTM data phase).
        S_ISSUE: r_state <= arbiter_busy ? S_BLOCK : S_IDLE;
        S_BLOCK: if (!arbiter_busy) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_msg = r_msg;
  assign gnt     = r_gnt;
  assign busy    = (r_state != S_IDLE);

`ifdef BUS_ARBITER_STATS_EN
  logic w_stall;
  assign w_stall = (|req) && !(|r_gnt);

  for (genvar g = 0; g < NUM_CACHE; g++) begin : g_gcnt
    bus_arbiter_sat16 u_gcnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (r_gnt[g]),
      .o_cnt (grant_cnt[g])
    );
  end

  bus_arbiter_sat16 u_scnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_stall),
    .o_cnt (stall_cnt)
  );
`endif

endmodule

`ifdef BUS_ARBITER_STATS_EN
// 16-bit event counter that sticks at all-ones instead of wrapping.
module bus_arbiter_sat16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  output logic [15:0] o_cnt
);
  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_cnt <= '0;
    else if (i_inc && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  end

  assign o_cnt = r_cnt;
endmodule
`endif

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (NUM_CACHE=4, XLEN=32). Stimulus pushes the
// expected grant (cycle, source, addr, tx) into a queue; a negedge monitor pops
// and compares whenever the DUT drives gnt or bus_msg.valid.
module tb_bus_arbiter;
  import types::*;

  localparam int NC = 4;
  localparam int XL = 32;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NC-1:0]          req;
  bus_tx_t [NC-1:0]       req_tx;
  logic [NC-1:0][XL-1:0]  req_addr;
  logic                   arbiter_busy;
  logic                   xbar_active;
  bus_msg_t               bus_msg;
  logic [NC-1:0]          gnt;
  logic                   busy;
`ifdef BUS_ARBITER_STATS_EN
  logic [NC-1:0][15:0]    grant_cnt;
  logic [15:0]            stall_cnt;
`endif

  bus_arbiter #(.NUM_CACHE(NC), .XLEN(XL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_tx       (req_tx),
    .req_addr     (req_addr),
    .arbiter_busy (arbiter_busy),
    .xbar_active  (xbar_active),
    .bus_msg      (bus_msg),
    .gnt          (gnt),
    .busy         (busy)
`ifdef BUS_ARBITER_STATS_EN
    ,
    .grant_cnt    (grant_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          cyc;
    int          src;
    logic [31:0] addr;
    bus_tx_t     tx;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  task automatic push(input int c, input int s, input logic [31:0] a, input bus_tx_t t);
    exp_t e;
    e.cyc = c; e.src = s; e.addr = a; e.tx = t;
    q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_msg.valid || gnt != '0) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_grant: got gnt=%b src=%0d expected none (cycle %0d)",
                   gnt, bus_msg.source, ncyc);
        end else begin
          exp_t          e;
          logic [NC-1:0] oh;
          e      = q.pop_front();
          oh     = '0;
          oh[e.src] = 1'b1;
          chk("grant_cycle", 64'(ncyc), 64'(e.cyc));
          chk("msg_valid",   64'(bus_msg.valid), 64'd1);
          chk("msg_source",  64'(bus_msg.source), 64'(e.src));
          chk("msg_addr",    64'(bus_msg.addr), 64'(e.addr));
          chk("msg_tx",      64'(bus_msg.bus_tx), 64'(e.tx));
          chk("gnt_onehot",  64'(gnt), 64'(oh));
        end
      end else if (bus_msg != '0) begin
        chk("idle_msg_zero", 64'(bus_msg), 64'd0);
      end
    end
  end

  int e0;

  initial begin
    rst_n = 1'b0; req = '0; arbiter_busy = 1'b0; xbar_active = 1'b0;
    req_tx[0] = GETS; req_tx[1] = GETM; req_tx[2] = PUTM; req_tx[3] = GETM;
    for (int i = 0; i < NC; i++) req_addr[i] = 32'h1000 + 32'(i) * 32'h40;
    #2;
    chk("reset_gnt",  64'(gnt), 64'd0);
    chk("reset_msg",  64'(bus_msg), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // All four request continuously: 0,1,2,3,0 on every other cycle.
    e0 = ncyc;
    req = 4'b1111;
    push(e0+1, 0, 32'h1000, GETS);
    push(e0+3, 1, 32'h1040, GETM);
    push(e0+5, 2, 32'h1080, PUTM);
    push(e0+7, 3, 32'h10C0, GETM);
    push(e0+9, 0, 32'h1000, GETS);
    tick(9);
    req = '0;
    tick(2);                                   // ptr = 1

    // PUTM from cache 2 makes memory busy for 3 cycles -> BLOCK, then cache 0.
    e0 = ncyc;
    req_addr[2] = 32'd5;
    req = 4'b0100;
    push(e0+1, 2, 32'd5, PUTM);
    tick(1);
    arbiter_busy = 1'b1;
    req = 4'b0001;
    push(e0+6, 0, 32'h1000, GETS);
    tick(1); chk("block_busy_1", 64'(busy), 64'd1);
    tick(1); chk("block_busy_2", 64'(busy), 64'd1);
    tick(1); chk("block_busy_3", 64'(busy), 64'd1);
    arbiter_busy = 1'b0;
    tick(1); chk("block_exit_idle", 64'(busy), 64'd0);
    tick(1);
    req = '0;
    tick(2);                                   // ptr = 1

    // xbar_active holds off selection for 4 cycles.
    e0 = ncyc;
    xbar_active = 1'b1;
    req = 4'b0001;
    tick(4);
    xbar_active = 1'b0;
    push(e0+5, 0, 32'h1000, GETS);
    tick(1);
    req = '0;
    tick(2);                                   // ptr = 1

    // Request dropped before it could be selected leaves no trace.
    xbar_active = 1'b1;
    req = 4'b1000;
    tick(2);
    req = '0;
    tick(1);
    xbar_active = 1'b0;
    tick(3);

    // Move ptr to 3, then 1001 -> 3 first, wrap to 0.
    e0 = ncyc;
    req = 4'b0100;
    push(e0+1, 2, 32'd5, PUTM);
    tick(1);
    req = 4'b1001;
    push(e0+3, 3, 32'h10C0, GETM);
    push(e0+5, 0, 32'h1000, GETS);
    tick(4);
    req = '0;
    tick(2);                                   // ptr = 1

    // Reset in the ISSUE cycle aborts the grant; ptr restarts at 0.
    req = 4'b0100;
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("abort_gnt",  64'(gnt), 64'd0);
    chk("abort_msg",  64'(bus_msg), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    req = 4'b1010;
    tick(1);
    rst_n = 1'b1;
    e0 = ncyc;
    chk("release_gnt",   64'(gnt), 64'd0);
    chk("release_valid", 64'(bus_msg.valid), 64'd0);
    push(e0+1, 1, 32'h1040, GETM);
    tick(1);
    req = '0;
    tick(2);

`ifdef BUS_ARBITER_STATS_EN
    chk("grant_cnt0", 64'(grant_cnt[0]), 64'd0);
    chk("grant_cnt1", 64'(grant_cnt[1]), 64'd1);
    chk("grant_cnt2", 64'(grant_cnt[2]), 64'd0);
    chk("grant_cnt3", 64'(grant_cnt[3]), 64'd0);
    arbiter_busy = 1'b1;
    req = 4'b0001;
    tick(70000);
    chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
    req = '0;
    arbiter_busy = 1'b0;
`endif

    tick(2);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
